// File: rtl/nes_joypad_ctrl_if.sv
// -----------------------------------------------------------------------------
// nes_joypad_ctrl_if
// CPU-side bus bundle for the NES controller port ($4016/$4017).
//
// Signals:
//   cpu_ce     one-cycle pulse marking a CPU bus cycle
//   cpu_addr   16-bit CPU address
//   cpu_we     1 = write, 0 = read (only meaningful while cpu_ce=1)
//   cpu_wdata  CPU write data
//   cpu_rdata  read data back to the CPU (valid while cpu_hit=1)
//   cpu_hit    access decoded to this block in the current cycle
//
// Handshake: cpu_ce is the only qualifier. There is no backpressure; the
// slave answers every qualified access in the same cycle (cpu_hit/cpu_rdata
// are combinational) and any state change takes effect at the next rising
// clock edge. With cpu_ce=0 the slave drives cpu_hit=0 and cpu_rdata=0.
// -----------------------------------------------------------------------------
interface nes_joypad_ctrl_if;
   logic        cpu_ce;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_hit;

   modport master (
      output cpu_ce, cpu_addr, cpu_we, cpu_wdata,
      input  cpu_rdata, cpu_hit
   );

   modport slave (
      input  cpu_ce, cpu_addr, cpu_we, cpu_wdata,
      output cpu_rdata, cpu_hit
   );
endinterface

// File: rtl/nes_joypad_ctrl.sv
// -----------------------------------------------------------------------------
// nes_joypad_ctrl
// NES standard controller port emulation for player 1. Two USB keyboard
// keycode slots are mapped onto the 8 NES buttons, and the 6502 strobe /
// serial-read protocol at $4016 is implemented. $4017 reads return an
// empty player-2 port; $4017 writes are left to the APU frame counter.
//
// Ports:
//   clk_clk        block clock (NES domain)
//   reset_reset_n  synchronous reset, active-low
//   keycode_a/b    keycode slots from the Nios PIO
//   cpu            CPU bus (nes_joypad_ctrl_if.slave)
//   buttons_dbg    registered live button vector
//                  bit 0=A 1=B 2=Select 3=Start 4=Up 5=Down 6=Left 7=Right
// -----------------------------------------------------------------------------
module nes_joypad_ctrl #(
   parameter logic [7:0] KC_A      = 8'h0E,
   parameter logic [7:0] KC_B      = 8'h0D,
   parameter logic [7:0] KC_SELECT = 8'h2C,
   parameter logic [7:0] KC_START  = 8'h28,
   parameter logic [7:0] KC_UP     = 8'h1A,
   parameter logic [7:0] KC_DOWN   = 8'h16,
   parameter logic [7:0] KC_LEFT   = 8'h04,
   parameter logic [7:0] KC_RIGHT  = 8'h07
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   input  logic [7:0]              keycode_a,
   input  logic [7:0]              keycode_b,
   nes_joypad_ctrl_if.slave        cpu,
   output logic [7:0]              buttons_dbg
);

   localparam logic [15:0] ADDR_JOY1 = 16'h4016;
   localparam logic [15:0] ADDR_JOY2 = 16'h4017;
   localparam logic [7:0]  OPEN_BUS  = 8'h40;

   logic [7:0] kc_a_q, kc_a_d;
   logic [7:0] kc_b_q, kc_b_d;
   logic [7:0] buttons_q, buttons_d;
   logic       strobe_q, strobe_d;
   logic [7:0] shift_q, shift_d;

   logic [7:0] raw;
   logic       wr_joy1;
   logic       rd_joy1;
   logic       rd_joy2;

   // Only bit 0 of the strobe write is meaningful.
   logic unused_wdata;
   assign unused_wdata = ^cpu.cpu_wdata[7:1];

   // A zero keycode is an empty slot and must never press a button, even
   // when a mapping parameter is itself zero.
   function automatic logic kc_match(input logic [7:0] kc, input logic [7:0] code);
      return (kc != 8'h00) && (kc == code);
   endfunction

   function automatic logic slot_match(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] code);
      return kc_match(a, code) || kc_match(b, code);
   endfunction

   // Keycode decode with SOCD cleaning: opposing directions cancel.
   always_comb begin
      raw       = '0;
      buttons_d = '0;
      raw[0] = slot_match(kc_a_q, kc_b_q, KC_A);
      raw[1] = slot_match(kc_a_q, kc_b_q, KC_B);
      raw[2] = slot_match(kc_a_q, kc_b_q, KC_SELECT);
      raw[3] = slot_match(kc_a_q, kc_b_q, KC_START);
      raw[4] = slot_match(kc_a_q, kc_b_q, KC_UP);
      raw[5] = slot_match(kc_a_q, kc_b_q, KC_DOWN);
      raw[6] = slot_match(kc_a_q, kc_b_q, KC_LEFT);
      raw[7] = slot_match(kc_a_q, kc_b_q, KC_RIGHT);
      buttons_d = raw;
      if (raw[4] && raw[5]) buttons_d[5:4] = 2'b00;
      if (raw[6] && raw[7]) buttons_d[7:6] = 2'b00;
   end

   // Bus decode. $4017 writes are deliberately not decoded.
   always_comb begin
      wr_joy1 = cpu.cpu_ce &&  cpu.cpu_we && (cpu.cpu_addr == ADDR_JOY1);
      rd_joy1 = cpu.cpu_ce && !cpu.cpu_we && (cpu.cpu_addr == ADDR_JOY1);
      rd_joy2 = cpu.cpu_ce && !cpu.cpu_we && (cpu.cpu_addr == ADDR_JOY2);
   end

   always_comb begin
      cpu.cpu_hit   = wr_joy1 || rd_joy1 || rd_joy2;
      cpu.cpu_rdata = 8'h00;
      if (rd_joy1)      cpu.cpu_rdata = OPEN_BUS | {7'b0, shift_q[0]};
      else if (rd_joy2) cpu.cpu_rdata = OPEN_BUS;
   end

   // Shift register: continuous reload while strobe is high; otherwise each
   // $4016 read shifts right, filling with 1 so reads past the 8th return 1.
   always_comb begin
      kc_a_d   = keycode_a;
      kc_b_d   = keycode_b;
      strobe_d = strobe_q;
      shift_d  = shift_q;
      if (wr_joy1) strobe_d = cpu.cpu_wdata[0];
      if (strobe_q)     shift_d = buttons_q;
      else if (rd_joy1) shift_d = {1'b1, shift_q[7:1]};
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         kc_a_q    <= 8'h00;
         kc_b_q    <= 8'h00;
         buttons_q <= 8'h00;
         strobe_q  <= 1'b0;
         shift_q   <= 8'h00;
      end else begin
         kc_a_q    <= kc_a_d;
         kc_b_q    <= kc_b_d;
         buttons_q <= buttons_d;
         strobe_q  <= strobe_d;
         shift_q   <= shift_d;
      end
   end

   assign buttons_dbg = buttons_q;

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
module tb_nes_joypad_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] ka;
   logic [7:0] kb;
   logic [7:0] btn;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];

   typedef struct {
      logic        ce;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        exp_hit;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t tbl[$];

   nes_joypad_ctrl_if bus();

   nes_joypad_ctrl dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .keycode_a     (ka),
      .keycode_b     (kb),
      .cpu           (bus),
      .buttons_dbg   (btn)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] model_buttons(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] codes [8];
      logic [7:0] r;
      codes = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};
      r = 8'h00;
      for (int i = 0; i < 8; i++)
         r[i] = (a != 8'h00 && a == codes[i]) || (b != 8'h00 && b == codes[i]);
      if (r[4] && r[5]) r[5:4] = 2'b00;
      if (r[6] && r[7]) r[7:6] = 2'b00;
      return r;
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // ---------------- driver tasks (entered at posedge+1) ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic access(input logic ce, input logic we, input logic [15:0] addr,
                         input logic [7:0] wd, input logic eh, input logic [7:0] er,
                         input string nm);
      logic [8:0] e;
      bus.cpu_ce    = ce;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wd;
      exp_q.push_back({eh, er});
      @(negedge clk);
      e = exp_q.pop_front();
      check(nm, {7'b0, bus.cpu_hit, bus.cpu_rdata}, {7'b0, e});
      @(posedge clk);
      #1;
      bus.cpu_ce    = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 16'h0000;
      bus.cpu_wdata = 8'h00;
   endtask

   task automatic rd16(input logic [7:0] er, input string nm);
      access(1'b1, 1'b0, 16'h4016, 8'h00, 1'b1, er, nm);
   endtask

   task automatic wr16(input logic [7:0] wd, input string nm);
      access(1'b1, 1'b1, 16'h4016, wd, 1'b1, 8'h00, nm);
   endtask

   task automatic run_table(input string nm);
      foreach (tbl[i])
         access(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                tbl[i].exp_hit, tbl[i].exp_rdata, $sformatf("%s[%0d]", nm, i));
   endtask

   function automatic vec_t v(input logic ce, input logic we, input logic [15:0] addr,
                              input logic [7:0] wd, input logic eh, input logic [7:0] er);
      vec_t t;
      t.ce = ce; t.we = we; t.addr = addr; t.wdata = wd; t.exp_hit = eh; t.exp_rdata = er;
      return t;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [7:0] pool [10];
      logic [7:0] m;

      rst_n = 1'b0;
      ka = 8'h00;
      kb = 8'h00;
      bus.cpu_ce = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
      idle(3);
      rst_n = 1'b1;

      // Reset state
      check("reset_buttons", {8'h00, btn}, 16'h0000);
      rd16(8'h40, "reset_read");

      // A + Start, strobe, 10 serial reads
      ka = 8'h0E; kb = 8'h28;
      idle(2);
      check("buttons_a_start", {8'h00, btn}, {8'h00, model_buttons(8'h0E, 8'h28)});
      tbl.delete();
      tbl.push_back(v(1, 1, 16'h4016, 8'h01, 1, 8'h00));
      tbl.push_back(v(1, 1, 16'h4016, 8'h00, 1, 8'h00));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h41));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h41));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h41));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h41));
      run_table("serial_a_start");

      // SOCD and 2-cycle latency
      ka = 8'h1A; kb = 8'h16;
      idle(2);
      check("socd_up_down", {8'h00, btn}, 16'h0000);
      kb = 8'h07;
      idle(1);
      check("latency_1cyc", {8'h00, btn}, 16'h0000);
      idle(1);
      check("latency_2cyc", {8'h00, btn}, 16'h0090);
      ka = 8'h04;
      idle(2);
      check("socd_left_right", {8'h00, btn}, 16'h0000);

      // Strobe held high: reads track live A, no shifting
      ka = 8'h0E; kb = 8'h00;
      idle(2);
      wr16(8'h01, "strobe_hold_set");
      for (int i = 0; i < 4; i++) begin
         ka = (i % 2 == 0) ? 8'h00 : 8'h0E;
         idle(3);
         rd16((i % 2 == 0) ? 8'h40 : 8'h41, $sformatf("strobe_live_a[%0d]", i));
      end
      wr16(8'h00, "strobe_hold_clr");
      rd16(8'h41, "after_strobe_a");
      rd16(8'h40, "after_strobe_b");

      // Reset mid-sequence, $4017 handling, undecoded address
      ka = 8'h0E; kb = 8'h28;
      idle(2);
      wr16(8'h01, "mid_set");
      wr16(8'h00, "mid_clr");
      rd16(8'h41, "mid_rd0");
      rd16(8'h40, "mid_rd1");
      rd16(8'h40, "mid_rd2");
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      rd16(8'h40, "post_reset_rd0");
      rd16(8'h40, "post_reset_rd1");
      access(1, 0, 16'h4017, 8'h00, 1, 8'h40, "read_4017");
      access(1, 1, 16'h4017, 8'h01, 0, 8'h00, "write_4017");
      access(1, 0, 16'h4015, 8'h00, 0, 8'h00, "read_4015");

      // Upper data bits ignored; cpu_ce=0 accesses ignored
      idle(2);
      tbl.delete();
      tbl.push_back(v(1, 1, 16'h4016, 8'hFF, 1, 8'h00));
      tbl.push_back(v(1, 1, 16'h4016, 8'hFE, 1, 8'h00));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h41));
      for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 16'h4016, 8'h00, 0, 8'h00));
      for (int i = 0; i < 2; i++) tbl.push_back(v(0, 1, 16'h4016, 8'h01, 0, 8'h00));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h41));
      tbl.push_back(v(1, 0, 16'h4016, 8'h00, 1, 8'h40));
      run_table("ce_idle");

      // Random keycode pairs through the full protocol
      pool = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h55};
      for (int n = 0; n < 8; n++) begin
         ka = pool[$urandom_range(0, 9)];
         kb = pool[$urandom_range(0, 9)];
         m  = model_buttons(ka, kb);
         idle(2);
         check($sformatf("rand_buttons[%0d]", n), {8'h00, btn}, {8'h00, m});
         wr16(8'h01, "rand_set");
         wr16(8'h00, "rand_clr");
         for (int b = 0; b < 8; b++)
            rd16(8'h40 | {7'b0, m[b]}, $sformatf("rand_bit[%0d][%0d]", n, b));
         rd16(8'h41, $sformatf("rand_fill[%0d]", n));
      end

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
